// File: rtl/layer_rom_arbiter.sv
// layer_rom_arbiter
//   Serves two tile-layer ROM clients (A and B) from one shared 32-bit
//   SDRAM read channel. Each client owns a one-entry hit cache (tag + last
//   data). Misses are queued in a one-deep pending slot per client. Slots
//   are granted round-robin, with at most one memory access outstanding.
//
// Ports
//   CLK_32M            system clock, rising edge
//   reset              asynchronous active-high reset
//   flush              synchronous; invalidates both cache tags
//   a_req/a_addr       client A request pulse and 32-bit aligned byte address
//   a_rdy/a_data       client A one-cycle ready pulse and data (data holds)
//   b_*                same as a_*, for client B
//   mem_req/mem_addr   level request and byte address to the SDRAM controller
//   mem_ack/mem_data   one-cycle acknowledge and read data from the SDRAM
module layer_rom_arbiter #(
    parameter logic [24:0] BASE_ADDR = 25'h0
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        flush,
    input  logic        a_req,
    input  logic [20:0] a_addr,
    output logic        a_rdy,
    output logic [31:0] a_data,
    input  logic        b_req,
    input  logic [20:0] b_addr,
    output logic        b_rdy,
    output logic [31:0] b_data,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    // Per-client state, index 0 = client A, index 1 = client B.
    logic [1:0]  req_s;
    logic [20:0] addr_s      [2];
    logic [1:0]  pend_v_r;
    logic [20:0] pend_addr_r [2];
    logic [1:0]  tag_v_r;
    logic [20:0] tag_addr_r  [2];
    logic [31:0] last_r      [2];
    logic [1:0]  fly_r;
    logic [1:0]  stale_r;
    logic [1:0]  rdy_r;
    logic [31:0] data_r      [2];

    // Shared arbitration state.
    logic        rr_last_r;     // client granted most recently (1 = B)
    logic        grant_r;       // owner of the outstanding access
    logic [20:0] iss_addr_r;    // client address of the outstanding access
    logic        mem_req_r;
    logic [24:0] mem_addr_r;

    // Decode results.
    logic        issue_s;
    logic        issue_sel_s;
    logic        ack_s;
    logic [1:0]  hit_s;
    logic [1:0]  done_s;
    logic [1:0]  stale_now_s;
    logic [1:0]  give_s;

    assign req_s     = {b_req, a_req};
    assign addr_s[0] = a_addr;
    assign addr_s[1] = b_addr;

    assign a_rdy    = rdy_r[0];
    assign b_rdy    = rdy_r[1];
    assign a_data   = data_r[0];
    assign b_data   = data_r[1];
    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

    // FSM state register.
    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: grant in IDLE, wait for the acknowledge in WAIT.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        issue_sel_s = 1'b0;
        ack_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_v_r[0] || pend_v_r[1]) begin
                    issue_s = 1'b1;
                    // A wins when alone, or on a tie when B went last.
                    if (pend_v_r[0] && (!pend_v_r[1] || rr_last_r)) begin
                        issue_sel_s = 1'b0;
                    end else begin
                        issue_sel_s = 1'b1;
                    end
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    ack_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Per-client decode: cache hit, completion, effective staleness, grant.
    always_comb begin
        hit_s       = 2'b00;
        done_s      = 2'b00;
        stale_now_s = 2'b00;
        give_s      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            // Hit is judged against the tag as it stands before any
            // completion in this same cycle updates it.
            hit_s[i]       = req_s[i] && tag_v_r[i] &&
                             (addr_s[i] == tag_addr_r[i]) && !flush;
            done_s[i]      = ack_s && (grant_r == 1'(i));
            // A new request arriving with the own ack makes that ack stale.
            stale_now_s[i] = stale_r[i] || (req_s[i] && fly_r[i]);
            give_s[i]      = issue_s && (issue_sel_s == 1'(i));
        end
    end

    // Memory port and arbitration registers.
    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= 25'h0;
            rr_last_r  <= 1'b1;
            grant_r    <= 1'b0;
            iss_addr_r <= 21'h0;
        end else begin
            if (issue_s) begin
                mem_req_r  <= 1'b1;
                mem_addr_r <= BASE_ADDR + {4'b0000, pend_addr_r[issue_sel_s]};
                rr_last_r  <= issue_sel_s;
                grant_r    <= issue_sel_s;
                iss_addr_r <= pend_addr_r[issue_sel_s];
            end else if (ack_s) begin
                mem_req_r <= 1'b0;
            end
        end
    end

    // Per-client pending slot, cache, in-flight tracking and ready outputs.
    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                pend_v_r[i]    <= 1'b0;
                pend_addr_r[i] <= 21'h0;
                tag_v_r[i]     <= 1'b0;
                tag_addr_r[i]  <= 21'h0;
                last_r[i]      <= 32'h0;
                fly_r[i]       <= 1'b0;
                stale_r[i]     <= 1'b0;
                rdy_r[i]       <= 1'b0;
                data_r[i]      <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rdy_r[i] <= hit_s[i] || (done_s[i] && !stale_now_s[i]);

                if (hit_s[i]) begin
                    data_r[i] <= last_r[i];
                end else if (done_s[i] && !stale_now_s[i]) begin
                    data_r[i] <= mem_data;
                end

                // A request written this cycle outranks the grant clearing.
                if (req_s[i]) begin
                    pend_v_r[i] <= !hit_s[i];
                    if (!hit_s[i]) begin
                        pend_addr_r[i] <= addr_s[i];
                    end
                end else if (give_s[i]) begin
                    pend_v_r[i] <= 1'b0;
                end

                // Completion refills the cache even after a flush.
                if (done_s[i]) begin
                    tag_v_r[i]    <= 1'b1;
                    tag_addr_r[i] <= iss_addr_r;
                    last_r[i]     <= mem_data;
                end else if (flush) begin
                    tag_v_r[i] <= 1'b0;
                end

                if (give_s[i]) begin
                    fly_r[i] <= 1'b1;
                end else if (done_s[i]) begin
                    fly_r[i] <= 1'b0;
                end

                if (done_s[i]) begin
                    stale_r[i] <= 1'b0;
                end else if (req_s[i] && fly_r[i]) begin
                    stale_r[i] <= 1'b1;
                end
            end
        end
    end

endmodule
